esfa_op_sequencer: RTL

Command-level controller for the ESFA memory-cell array. It accepts one host command at a time over a valid/ready handshake and broadcasts the matching cell selector sequence on the shared cell bus. It then reduces the N registered cell responses with a lowest-index priority select and returns a single result over a valid/ready response channel. It sits between the host/test harness and the array of memory cells, and is the only driver of the cell bus.

---
 rtl/esfa_pkg.sv | 36 +++
 rtl/esfa_hit_select.sv | 42 ++++
 rtl/esfa_op_sequencer.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/esfa_pkg.sv
// esfa_pkg
// Shared definitions for the ESFA op sequencer and its helpers:
//   - ESFA_W             default data / handle / array-code width
//   - SEL_*              cell-bus selector opcodes (8-bit)
//   - op_e               host command opcodes carried on cmd_op
//   - state_e            sequencer FSM states
package esfa_pkg;

    localparam int ESFA_W = 8;

    localparam logic [7:0] SEL_UPDATE       = 8'd0;
    localparam logic [7:0] SEL_LOOKUP_SCAN  = 8'd1;
    localparam logic [7:0] SEL_ENCODE       = 8'd2;
    localparam logic [7:0] SEL_CONGRUE_UP   = 8'd3;
    localparam logic [7:0] SEL_CONGRUE_DOWN = 8'd4;
    localparam logic [7:0] SEL_MARK_AVAIL   = 8'd5;
    localparam logic [7:0] SEL_ENRANK       = 8'd6;
    localparam logic [7:0] SEL_NOP          = 8'd8;

    typedef enum logic [1:0] {
        OP_LOOKUP = 2'd0,
        OP_ALLOC  = 2'd1,
        OP_DELETE = 2'd2,
        OP_RANK   = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        SAMPLE  = 3'd2,
        ISSUE2  = 3'd3,
        SAMPLE2 = 3'd4,
        RESP    = 3'd5
    } state_e;

endpackage

// File: rtl/esfa_hit_select.sv
// esfa_hit_select
// Combinational lowest-index priority select over the per-cell responses.
// Ports:
//   bool_i     per-cell match flags
//   result_i   packed per-cell results, cell k at [k*W +: W]
//   context_i  packed per-cell contexts, same packing
//   anyHit_o   at least one flag set
//   hitIdx_o   index (handle) of the lowest set flag, 0 when none
//   result_o   result of the selected cell, 0 when none
//   context_o  context of the selected cell, 0 when none
module esfa_hit_select
    import esfa_pkg::*;
#(
    parameter int N_CELLS = 8,
    parameter int W       = ESFA_W
) (
    input  logic [N_CELLS-1:0]   bool_i,
    input  logic [N_CELLS*W-1:0] result_i,
    input  logic [N_CELLS*W-1:0] context_i,
    output logic                 anyHit_o,
    output logic [W-1:0]         hitIdx_o,
    output logic [W-1:0]         result_o,
    output logic [W-1:0]         context_o
);

    // Walking from the top index down lets the lowest set flag overwrite
    // any higher one, which gives lowest-index priority without a break.
    always_comb begin
        anyHit_o  = |bool_i;
        hitIdx_o  = '0;
        result_o  = '0;
        context_o = '0;
        for (int k = N_CELLS - 1; k >= 0; k--) begin
            if (bool_i[k]) begin
                hitIdx_o  = W'(k);
                result_o  = result_i[k*W +: W];
                context_o = context_i[k*W +: W];
            end
        end
    end

endmodule

// File: rtl/esfa_op_sequencer.sv
// esfa_op_sequencer
// Command-level controller for the ESFA cell array. Takes one host command
// at a time, drives the selector sequence on the shared cell bus, reduces
// the registered cell responses and returns one result.
// Ports:
//   clk, reset            clock, synchronous active-low reset
//   cmd_valid/cmd_ready   command handshake (ready only in IDLE)
//   cmd_op/array/index/value  command fields
//   rsp_valid/rsp_ready   response handshake, response held until accepted
//   rsp_hit/value/rank    response fields
//   cell_selector, cell_metadata, cell_index, cell_value, cell_is_metadata
//                         registered broadcast bus, NOP when idle
//   cell_bool, cell_result, cell_context  registered per-cell responses
module esfa_op_sequencer
    import esfa_pkg::*;
#(
    parameter int N_CELLS = 8,
    parameter int W       = ESFA_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [1:0]           cmd_op,
    input  logic [W-1:0]         cmd_array,
    input  logic [W-1:0]         cmd_index,
    input  logic [W-1:0]         cmd_value,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic                 rsp_hit,
    output logic [W-1:0]         rsp_value,
    output logic [W-1:0]         rsp_rank,
    output logic [7:0]           cell_selector,
    output logic [W-1:0]         cell_metadata,
    output logic [W-1:0]         cell_index,
    output logic [W-1:0]         cell_value,
    output logic                 cell_is_metadata,
    input  logic [N_CELLS-1:0]   cell_bool,
    input  logic [N_CELLS*W-1:0] cell_result,
    input  logic [N_CELLS*W-1:0] cell_context
);

    state_e       state_q, state_d;
    op_e          op_q, op_d;
    logic [W-1:0] index_q, index_d;
    logic [W-1:0] value_q, value_d;
    logic [W-1:0] handle_q, handle_d;

    logic [7:0]   busSel_q, busSel_d;
    logic [W-1:0] busMeta_q, busMeta_d;
    logic [W-1:0] busIndex_q, busIndex_d;
    logic [W-1:0] busValue_q, busValue_d;
    logic         busIsMeta_q, busIsMeta_d;

    logic         rspHit_q, rspHit_d;
    logic [W-1:0] rspValue_q, rspValue_d;
    logic [W-1:0] rspRank_q, rspRank_d;

    logic         anyHit;
    logic [W-1:0] hitIdx;
    logic [W-1:0] hitResult;
    logic [W-1:0] hitContext;
    logic         cmdAccept;

    esfa_hit_select #(
        .N_CELLS (N_CELLS),
        .W       (W)
    ) u_hit_select (
        .bool_i    (cell_bool),
        .result_i  (cell_result),
        .context_i (cell_context),
        .anyHit_o  (anyHit),
        .hitIdx_o  (hitIdx),
        .result_o  (hitResult),
        .context_o (hitContext)
    );

    assign cmdAccept = cmd_valid && cmd_ready;

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. Only a successful ALLOC takes the second issue/sample
    // pass; a full array skips the write entirely.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cmdAccept) state_d = ISSUE;
            ISSUE:   state_d = SAMPLE;
            SAMPLE:  state_d = (op_q == OP_ALLOC && anyHit) ? ISSUE2 : RESP;
            ISSUE2:  state_d = SAMPLE2;
            SAMPLE2: state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs. cmd_ready is also gated by reset so it stays low for
    // the whole time reset is held, not only until the first edge.
    always_comb begin
        cmd_ready = reset && (state_q == IDLE);
        rsp_valid = (state_q == RESP);
    end

    // Datapath next values. The bus falls back to NOP with zero operands every
    // cycle it is not explicitly loaded, so mutating selectors last exactly
    // one cycle and are always followed by a NOP gap.
    always_comb begin
        op_d        = op_q;
        index_d     = index_q;
        value_d     = value_q;
        handle_d    = handle_q;
        busSel_d    = SEL_NOP;
        busMeta_d   = '0;
        busIndex_d  = '0;
        busValue_d  = '0;
        busIsMeta_d = 1'b0;
        rspHit_d    = rspHit_q;
        rspValue_d  = rspValue_q;
        rspRank_d   = rspRank_q;

        case (state_q)
            IDLE: begin
                if (cmdAccept) begin
                    op_d       = op_e'(cmd_op);
                    index_d    = cmd_index;
                    value_d    = cmd_value;
                    rspHit_d   = 1'b0;
                    rspValue_d = '0;
                    rspRank_d  = '0;
                    case (op_e'(cmd_op))
                        OP_LOOKUP: begin
                            busSel_d    = SEL_LOOKUP_SCAN;
                            busMeta_d   = cmd_array;
                            busIndex_d  = cmd_index;
                            busIsMeta_d = 1'b1;
                        end
                        OP_RANK: begin
                            busSel_d    = SEL_ENRANK;
                            busMeta_d   = cmd_array;
                            busIsMeta_d = 1'b1;
                        end
                        OP_ALLOC: begin
                            busSel_d = SEL_MARK_AVAIL;
                        end
                        OP_DELETE: begin
                            busSel_d    = SEL_CONGRUE_DOWN;
                            busMeta_d   = cmd_array;
                            busIndex_d  = cmd_index;
                            busIsMeta_d = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end

            SAMPLE: begin
                case (op_q)
                    OP_ALLOC: begin
                        if (anyHit) begin
                            // Lowest free cell becomes the handle; the write
                            // addresses it through the metadata operand.
                            handle_d    = hitIdx;
                            busSel_d    = SEL_UPDATE;
                            busMeta_d   = hitIdx;
                            busIndex_d  = index_q;
                            busValue_d  = value_q;
                            busIsMeta_d = 1'b1;
                        end else begin
                            rspHit_d   = 1'b0;
                            rspValue_d = '0;
                            rspRank_d  = '0;
                        end
                    end
                    OP_DELETE: begin
                        rspHit_d   = 1'b1;
                        rspValue_d = '0;
                        rspRank_d  = '0;
                    end
                    default: begin
                        rspHit_d   = anyHit;
                        rspValue_d = hitResult;
                        rspRank_d  = hitContext;
                    end
                endcase
            end

            SAMPLE2: begin
                rspHit_d   = 1'b1;
                rspValue_d = handle_q;
                rspRank_d  = '0;
            end

            RESP: begin
                if (rsp_ready) begin
                    rspHit_d   = 1'b0;
                    rspValue_d = '0;
                    rspRank_d  = '0;
                end
            end

            default: ;
        endcase
    end

    // Datapath registers: latched command, bus drivers and response fields.
    always_ff @(posedge clk) begin
        if (!reset) begin
            op_q        <= OP_LOOKUP;
            index_q     <= '0;
            value_q     <= '0;
            handle_q    <= '0;
            busSel_q    <= SEL_NOP;
            busMeta_q   <= '0;
            busIndex_q  <= '0;
            busValue_q  <= '0;
            busIsMeta_q <= 1'b0;
            rspHit_q    <= 1'b0;
            rspValue_q  <= '0;
            rspRank_q   <= '0;
        end else begin
            op_q        <= op_d;
            index_q     <= index_d;
            value_q     <= value_d;
            handle_q    <= handle_d;
            busSel_q    <= busSel_d;
            busMeta_q   <= busMeta_d;
            busIndex_q  <= busIndex_d;
            busValue_q  <= busValue_d;
            busIsMeta_q <= busIsMeta_d;
            rspHit_q    <= rspHit_d;
            rspValue_q  <= rspValue_d;
            rspRank_q   <= rspRank_d;
        end
    end

    assign cell_selector    = busSel_q;
    assign cell_metadata    = busMeta_q;
    assign cell_index       = busIndex_q;
    assign cell_value       = busValue_q;
    assign cell_is_metadata = busIsMeta_q;
    assign rsp_hit          = rspHit_q;
    assign rsp_value        = rspValue_q;
    assign rsp_rank         = rspRank_q;

endmodule
